aftab_csr_trap_sequencer: RTL and testbench

Multi-cycle controller that owns the write port of the AFTAB interrupt CSR register bank. It arbitrates between three requesters: CSR instructions, trap entry and mret. Each request becomes a fixed sequence of bank reads and writes, and the block returns read data or a jump target. It sits between the core control unit and the CSR register bank, and is the only driver of writeRegBank, addressRegBank and inputRegBank.

---
 rtl/aftab_csr_trap_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_aftab_csr_trap_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aftab_csr_trap_sequencer.sv
// Write-port owner of the AFTAB interrupt CSR bank: arbitrates CSR instructions, trap entry
// and mret, and steps each through a fixed read/modify/write sequence on the bank.
module aftab_csr_trap_sequencer #(
    parameter int len = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_csrReq,
    input  logic [1:0]      i_csrOp,
    input  logic [11:0]     i_csrAddr,
    input  logic [len-1:0]  i_csrWdata,
    output logic            o_csrDone,
    output logic [len-1:0]  o_csrRdata,
    input  logic            i_trapReq,
    input  logic [len-1:0]  i_trapCause,
    input  logic [len-1:0]  i_trapPc,
    input  logic [len-1:0]  i_trapVal,
    output logic            o_trapDone,
    output logic [len-1:0]  o_trapTarget,
    input  logic            i_mretReq,
    output logic            o_mretDone,
    output logic [len-1:0]  o_mretTarget,
    output logic            o_busy,
    output logic            o_writeRegBank,
    output logic [11:0]     o_addressRegBank,
    output logic [len-1:0]  o_inputRegBank,
    input  logic [len-1:0]  i_outRegBank
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_CSR_RD   = 4'd1;
    localparam logic [3:0] S_CSR_WR   = 4'd2;
    localparam logic [3:0] S_TR_RST   = 4'd3;
    localparam logic [3:0] S_TR_WST   = 4'd4;
    localparam logic [3:0] S_TR_EPC   = 4'd5;
    localparam logic [3:0] S_TR_CAUSE = 4'd6;
    localparam logic [3:0] S_TR_TVAL  = 4'd7;
    localparam logic [3:0] S_TR_VEC   = 4'd8;
    localparam logic [3:0] S_TR_DONE  = 4'd9;
    localparam logic [3:0] S_MR_RST   = 4'd10;
    localparam logic [3:0] S_MR_WST   = 4'd11;
    localparam logic [3:0] S_MR_EPC   = 4'd12;
    localparam logic [3:0] S_MR_DONE  = 4'd13;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    logic [3:0]     r_state;
    logic [1:0]     r_csrOp;
    logic [11:0]    r_csrAddr;
    logic [len-1:0] r_csrWdata;
    logic [len-1:0] r_trapCause;
    logic [len-1:0] r_trapPc;
    logic [len-1:0] r_trapVal;

    logic [3:0]     w_nextState;
    logic [len-1:0] w_csrNew;
    logic           w_csrWe;
    logic [len-1:0] w_trStatus;
    logic [len-1:0] w_mrStatus;
    logic [len-1:0] w_tvecBase;
    logic [len-1:0] w_trapTarget;

    // Next-state selection; arbitration only in IDLE with trap > mret > csr.
    always_comb begin
        w_nextState = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (i_trapReq)      w_nextState = S_TR_RST;
                else if (i_mretReq) w_nextState = S_MR_RST;
                else if (i_csrReq)  w_nextState = S_CSR_RD;
                else                w_nextState = S_IDLE;
            end
            S_CSR_RD:   w_nextState = S_CSR_WR;
            S_CSR_WR:   w_nextState = S_IDLE;
            S_TR_RST:   w_nextState = S_TR_WST;
            S_TR_WST:   w_nextState = S_TR_EPC;
            S_TR_EPC:   w_nextState = S_TR_CAUSE;
            S_TR_CAUSE: w_nextState = S_TR_TVAL;
            S_TR_TVAL:  w_nextState = S_TR_VEC;
            S_TR_VEC:   w_nextState = S_TR_DONE;
            S_TR_DONE:  w_nextState = S_IDLE;
            S_MR_RST:   w_nextState = S_MR_WST;
            S_MR_WST:   w_nextState = S_MR_EPC;
            S_MR_EPC:   w_nextState = S_MR_DONE;
            S_MR_DONE:  w_nextState = S_IDLE;
            default:    w_nextState = S_IDLE;
        endcase
    end

    // Data-path values computed from the bank read of the current state.
    always_comb begin
        case (r_csrOp)
            2'b10:   w_csrNew = i_outRegBank | r_csrWdata;
            2'b11:   w_csrNew = i_outRegBank & ~r_csrWdata;
            default: w_csrNew = r_csrWdata;
        endcase
        if (r_csrOp == 2'b10 || r_csrOp == 2'b11) begin
            w_csrWe = (r_csrWdata != {len{1'b0}});
        end else begin
            w_csrWe = 1'b1;
        end
        w_trStatus    = i_outRegBank;
        w_trStatus[7] = i_outRegBank[3];
        w_trStatus[3] = 1'b0;
        w_mrStatus    = i_outRegBank;
        w_mrStatus[3] = i_outRegBank[7];
        w_mrStatus[7] = 1'b1;
        w_tvecBase    = {i_outRegBank[len-1:2], 2'b00};
        if (i_outRegBank[1:0] == 2'b01 && r_trapCause[len-1]) begin
            w_trapTarget = w_tvecBase + {r_trapCause[len-3:0], 2'b00};
        end else begin
            w_trapTarget = w_tvecBase;
        end
    end

    // Outputs are registered for the state being entered, so each state's drive is stable all cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state          <= S_IDLE;
            r_csrOp          <= 2'b00;
            r_csrAddr        <= 12'h000;
            r_csrWdata       <= {len{1'b0}};
            r_trapCause      <= {len{1'b0}};
            r_trapPc         <= {len{1'b0}};
            r_trapVal        <= {len{1'b0}};
            o_busy           <= 1'b0;
            o_writeRegBank   <= 1'b0;
            o_addressRegBank <= 12'h000;
            o_inputRegBank   <= {len{1'b0}};
            o_csrDone        <= 1'b0;
            o_csrRdata       <= {len{1'b0}};
            o_trapDone       <= 1'b0;
            o_trapTarget     <= {len{1'b0}};
            o_mretDone       <= 1'b0;
            o_mretTarget     <= {len{1'b0}};
        end else begin
            r_state          <= w_nextState;
            o_busy           <= (w_nextState != S_IDLE);
            o_writeRegBank   <= 1'b0;
            o_addressRegBank <= 12'h000;
            o_inputRegBank   <= {len{1'b0}};
            o_csrDone        <= 1'b0;
            o_csrRdata       <= {len{1'b0}};
            o_trapDone       <= 1'b0;
            o_trapTarget     <= {len{1'b0}};
            o_mretDone       <= 1'b0;
            o_mretTarget     <= {len{1'b0}};
            case (r_state)
                S_IDLE: begin
                    if (i_trapReq) begin
                        r_trapCause      <= i_trapCause;
                        r_trapPc         <= {i_trapPc[len-1:2], 2'b00};
                        r_trapVal        <= i_trapVal;
                        o_addressRegBank <= A_MSTATUS;
                    end else if (i_mretReq) begin
                        o_addressRegBank <= A_MSTATUS;
                    end else if (i_csrReq) begin
                        r_csrOp          <= i_csrOp;
                        r_csrAddr        <= i_csrAddr;
                        r_csrWdata       <= i_csrWdata;
                        o_addressRegBank <= i_csrAddr;
                    end else begin
                        o_addressRegBank <= 12'h000;
                    end
                end
                S_CSR_RD: begin
                    o_addressRegBank <= r_csrAddr;
                    o_writeRegBank   <= w_csrWe;
                    o_inputRegBank   <= w_csrNew;
                    o_csrDone        <= 1'b1;
                    o_csrRdata       <= i_outRegBank;
                end
                S_TR_RST: begin
                    o_addressRegBank <= A_MSTATUS;
                    o_writeRegBank   <= 1'b1;
                    o_inputRegBank   <= w_trStatus;
                end
                S_TR_WST: begin
                    o_addressRegBank <= A_MEPC;
                    o_writeRegBank   <= 1'b1;
                    o_inputRegBank   <= r_trapPc;
                end
                S_TR_EPC: begin
                    o_addressRegBank <= A_MCAUSE;
                    o_writeRegBank   <= 1'b1;
                    o_inputRegBank   <= r_trapCause;
                end
                S_TR_CAUSE: begin
                    o_addressRegBank <= A_MTVAL;
                    o_writeRegBank   <= 1'b1;
                    o_inputRegBank   <= r_trapVal;
                end
                S_TR_TVAL: o_addressRegBank <= A_MTVEC;
                S_TR_VEC: begin
                    o_addressRegBank <= A_MTVEC;
                    o_trapDone       <= 1'b1;
                    o_trapTarget     <= w_trapTarget;
                end
                S_MR_RST: begin
                    o_addressRegBank <= A_MSTATUS;
                    o_writeRegBank   <= 1'b1;
                    o_inputRegBank   <= w_mrStatus;
                end
                S_MR_WST: o_addressRegBank <= A_MEPC;
                S_MR_EPC: begin
                    o_addressRegBank <= A_MEPC;
                    o_mretDone       <= 1'b1;
                    o_mretTarget     <= i_outRegBank;
                end
                default: o_addressRegBank <= 12'h000;
            endcase
        end
    end

endmodule

// File: tb/tb_aftab_csr_trap_sequencer.sv
// Directed bench for aftab_csr_trap_sequencer with a behavioural CSR bank and write log.
module tb_aftab_csr_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        csrReq;
    logic [1:0]  csrOp;
    logic [11:0] csrAddr;
    logic [31:0] csrWdata;
    logic        csrDone;
    logic [31:0] csrRdata;
    logic        trapReq;
    logic [31:0] trapCause, trapPc, trapVal;
    logic        trapDone;
    logic [31:0] trapTarget;
    logic        mretReq;
    logic        mretDone;
    logic [31:0] mretTarget;
    logic        busy;
    logic        writeRegBank;
    logic [11:0] addressRegBank;
    logic [31:0] inputRegBank;
    logic [31:0] outRegBank;

    logic [31:0] bank [0:4095];
    logic        pl_we = 1'b0;
    logic [11:0] pl_a = 12'h000;
    logic [31:0] pl_d = 32'h0;
    logic [11:0] log_a [0:255];
    logic [31:0] log_d [0:255];
    int          wr_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    aftab_csr_trap_sequencer #(.len(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_csrReq(csrReq), .i_csrOp(csrOp), .i_csrAddr(csrAddr), .i_csrWdata(csrWdata),
        .o_csrDone(csrDone), .o_csrRdata(csrRdata),
        .i_trapReq(trapReq), .i_trapCause(trapCause), .i_trapPc(trapPc), .i_trapVal(trapVal),
        .o_trapDone(trapDone), .o_trapTarget(trapTarget),
        .i_mretReq(mretReq), .o_mretDone(mretDone), .o_mretTarget(mretTarget),
        .o_busy(busy), .o_writeRegBank(writeRegBank), .o_addressRegBank(addressRegBank),
        .o_inputRegBank(inputRegBank), .i_outRegBank(outRegBank)
    );

    assign outRegBank = bank[addressRegBank];

    // Bank model: bench preloads take the port while the DUT is idle; DUT writes are logged.
    always @(posedge clk) begin
        if (pl_we) begin
            bank[pl_a] <= pl_d;
        end else if (writeRegBank) begin
            bank[addressRegBank] <= inputRegBank;
            log_a[wr_cnt[7:0]]   <= addressRegBank;
            log_d[wr_cnt[7:0]]   <= inputRegBank;
            wr_cnt               <= wr_cnt + 1;
        end
    end

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_a = a; pl_d = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Waits (bounded) for the selected done pulse; n is the cycle offset from accept, -1 on timeout.
    task automatic wait_done(input int which, output int n);
        n = -1;
        for (int k = 1; k <= 20 && n < 0; k++) begin
            @(negedge clk);
            if ((which == 0 && csrDone) || (which == 1 && trapDone) || (which == 2 && mretDone))
                n = k;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        csrReq = 1'b0; csrOp = 2'b00; csrAddr = 12'h000; csrWdata = 32'h0;
        trapReq = 1'b0; trapCause = 32'h0; trapPc = 32'h0; trapVal = 32'h0;
        mretReq = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, writeRegBank, csrDone, trapDone, mretDone} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags got %b want 00000", {busy, writeRegBank, csrDone, trapDone, mretDone});
        end
        n_cmp++;
        if (addressRegBank !== 12'h000 || inputRegBank !== 32'h0) begin
            n_bad++; $display("FAIL reset_bus got addr %h data %h want 0/0", addressRegBank, inputRegBank);
        end
        n_cmp++;
        if (csrRdata !== 32'h0 || trapTarget !== 32'h0 || mretTarget !== 32'h0) begin
            n_bad++; $display("FAIL reset_data got %h %h %h want 0", csrRdata, trapTarget, mretTarget);
        end
        rst = 1'b0;
    endtask

    task automatic test_csr_rw();
        int n, base;
        logic we; logic [11:0] a; logic [31:0] d, rd;
        preload(12'h340, 32'h0000_0011);
        base = wr_cnt;
        csrReq = 1'b1; csrOp = 2'b01; csrAddr = 12'h340; csrWdata = 32'hDEAD_BEEF;
        wait_done(0, n);
        we = writeRegBank; a = addressRegBank; d = inputRegBank; rd = csrRdata;
        csrReq = 1'b0;
        n_cmp++;
        if (n !== 2) begin n_bad++; $display("FAIL csr_rw_latency got %0d want 2", n); end
        n_cmp++;
        if (rd !== 32'h11) begin n_bad++; $display("FAIL csr_rw_rdata got %h want 00000011", rd); end
        n_cmp++;
        if (we !== 1'b1 || a !== 12'h340 || d !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL csr_rw_write got we %b addr %h data %h want 1 340 deadbeef", we, a, d);
        end
        @(negedge clk);
        n_cmp++;
        if (csrDone !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL csr_rw_pulse got done %b busy %b want 0 0", csrDone, busy);
        end
        n_cmp++;
        if (bank[12'h340] !== 32'hDEAD_BEEF || wr_cnt - base !== 1) begin
            n_bad++; $display("FAIL csr_rw_bank got %h writes %0d want deadbeef 1", bank[12'h340], wr_cnt - base);
        end
    endtask

    task automatic test_csr_rs_rc();
        int n, base;
        logic we; logic [31:0] rd;
        preload(12'h300, 32'h0000_0088);
        base = wr_cnt;
        csrReq = 1'b1; csrOp = 2'b10; csrAddr = 12'h300; csrWdata = 32'h0;
        wait_done(0, n);
        we = writeRegBank; rd = csrRdata;
        csrReq = 1'b0;
        n_cmp++;
        if (n !== 2 || rd !== 32'h88) begin
            n_bad++; $display("FAIL csr_rs0_done got n %0d rdata %h want 2 00000088", n, rd);
        end
        @(negedge clk);
        n_cmp++;
        if (we !== 1'b0 || wr_cnt - base !== 0) begin
            n_bad++; $display("FAIL csr_rs0_nowrite got we %b writes %0d want 0 0", we, wr_cnt - base);
        end
        csrReq = 1'b1; csrOp = 2'b11; csrAddr = 12'h300; csrWdata = 32'h8;
        wait_done(0, n);
        rd = csrRdata;
        csrReq = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (n !== 2 || rd !== 32'h88 || bank[12'h300] !== 32'h80) begin
            n_bad++; $display("FAIL csr_rc got n %0d rdata %h mstatus %h want 2 88 80", n, rd, bank[12'h300]);
        end
    endtask

    task automatic test_trap();
        int n, base;
        logic [31:0] tgt;
        preload(12'h300, 32'h0000_0008);
        preload(12'h305, 32'h0000_1001);
        base = wr_cnt;
        trapReq = 1'b1; trapCause = 32'h8000_0007; trapPc = 32'h203; trapVal = 32'h55;
        wait_done(1, n);
        tgt = trapTarget;
        trapReq = 1'b0;
        n_cmp++;
        if (n !== 7 || tgt !== 32'h101C) begin
            n_bad++; $display("FAIL trap_vec got n %0d target %h want 7 0000101c", n, tgt);
        end
        @(negedge clk);
        n_cmp++;
        if (trapDone !== 1'b0 || busy !== 1'b0 || wr_cnt - base !== 4) begin
            n_bad++; $display("FAIL trap_end got done %b busy %b writes %0d want 0 0 4", trapDone, busy, wr_cnt - base);
        end
        n_cmp++;
        if (log_a[base] !== 12'h300 || log_d[base] !== 32'h80 || log_a[base+1] !== 12'h341 || log_d[base+1] !== 32'h200) begin
            n_bad++; $display("FAIL trap_wr01 got %h=%h %h=%h want 300=80 341=200",
                              log_a[base], log_d[base], log_a[base+1], log_d[base+1]);
        end
        n_cmp++;
        if (log_a[base+2] !== 12'h342 || log_d[base+2] !== 32'h8000_0007 || log_a[base+3] !== 12'h343 || log_d[base+3] !== 32'h55) begin
            n_bad++; $display("FAIL trap_wr23 got %h=%h %h=%h want 342=80000007 343=55",
                              log_a[base+2], log_d[base+2], log_a[base+3], log_d[base+3]);
        end
        preload(12'h305, 32'h0000_1000);
        trapReq = 1'b1;
        wait_done(1, n);
        tgt = trapTarget;
        trapReq = 1'b0;
        n_cmp++;
        if (n !== 7 || tgt !== 32'h1000) begin
            n_bad++; $display("FAIL trap_direct got n %0d target %h want 7 00001000", n, tgt);
        end
        @(negedge clk);
    endtask

    task automatic test_mret();
        int n, base;
        logic [31:0] tgt;
        preload(12'h300, 32'h0000_0080);
        preload(12'h341, 32'h0000_0200);
        base = wr_cnt;
        mretReq = 1'b1;
        wait_done(2, n);
        tgt = mretTarget;
        mretReq = 1'b0;
        n_cmp++;
        if (n !== 4 || tgt !== 32'h200) begin
            n_bad++; $display("FAIL mret_done got n %0d target %h want 4 00000200", n, tgt);
        end
        @(negedge clk);
        n_cmp++;
        if (wr_cnt - base !== 1 || log_a[base] !== 12'h300 || log_d[base] !== 32'h88) begin
            n_bad++; $display("FAIL mret_wr got writes %0d %h=%h want 1 300=88", wr_cnt - base, log_a[base], log_d[base]);
        end
    endtask

    task automatic test_back_to_back();
        int t_n = -1, m_n = -1, c_n = -1, idle = 0;
        logic [31:0] t_tgt = 32'h0, m_tgt = 32'h0, c_rd = 32'h0;
        preload(12'h300, 32'h0000_0008);
        preload(12'h305, 32'h0000_1000);
        preload(12'h340, 32'h0000_0077);
        trapReq = 1'b1; trapCause = 32'h2; trapPc = 32'h104; trapVal = 32'h9;
        mretReq = 1'b1;
        csrReq = 1'b1; csrOp = 2'b01; csrAddr = 12'h340; csrWdata = 32'h5;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (trapDone) begin t_n = k; t_tgt = trapTarget; trapReq = 1'b0; end
            if (mretDone) begin m_n = k; m_tgt = mretTarget; mretReq = 1'b0; end
            if (csrDone)  begin c_n = k; c_rd = csrRdata;    csrReq = 1'b0;  end
            if (!busy && k <= 15) idle++;
        end
        trapReq = 1'b0; mretReq = 1'b0; csrReq = 1'b0;
        n_cmp++;
        if (t_n !== 7 || m_n !== 12 || c_n !== 15) begin
            n_bad++; $display("FAIL b2b_order got trap %0d mret %0d csr %0d want 7 12 15", t_n, m_n, c_n);
        end
        n_cmp++;
        if (idle !== 2) begin n_bad++; $display("FAIL b2b_idle got %0d idle cycles want 2", idle); end
        n_cmp++;
        if (t_tgt !== 32'h1000 || m_tgt !== 32'h104 || c_rd !== 32'h77) begin
            n_bad++; $display("FAIL b2b_data got %h %h %h want 00001000 00000104 00000077", t_tgt, m_tgt, c_rd);
        end
        n_cmp++;
        if (bank[12'h300] !== 32'h88 || bank[12'h340] !== 32'h5) begin
            n_bad++; $display("FAIL b2b_bank got mstatus %h csr340 %h want 88 5", bank[12'h300], bank[12'h340]);
        end
    endtask

    task automatic test_reset_mid();
        logic we; logic [11:0] a;
        preload(12'h300, 32'h0000_0008);
        preload(12'h342, 32'h0000_AAAA);
        preload(12'h343, 32'h0000_BBBB);
        trapReq = 1'b1; trapCause = 32'h3; trapPc = 32'h400; trapVal = 32'h99;
        repeat (3) @(negedge clk);
        we = writeRegBank; a = addressRegBank;
        rst = 1'b1; trapReq = 1'b0;
        n_cmp++;
        if (we !== 1'b1 || a !== 12'h341) begin
            n_bad++; $display("FAIL rstmid_epc got we %b addr %h want 1 341", we, a);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, writeRegBank, trapDone} !== 3'b0 || addressRegBank !== 12'h0 || inputRegBank !== 32'h0 || trapTarget !== 32'h0) begin
            n_bad++; $display("FAIL rstmid_outputs got busy %b we %b done %b addr %h data %h tgt %h want all 0",
                              busy, writeRegBank, trapDone, addressRegBank, inputRegBank, trapTarget);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (bank[12'h342] !== 32'hAAAA || bank[12'h343] !== 32'hBBBB || busy !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_nowrite got mcause %h mtval %h busy %b want aaaa bbbb 0",
                              bank[12'h342], bank[12'h343], busy);
        end
    endtask

    initial begin
        test_reset();
        test_csr_rw();
        test_csr_rs_rc();
        test_trap();
        test_mret();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
